array_shift_down: RTL

- Multi-cycle engine for the `shiftDown` array instruction; the inverse of `shiftUp`.
- Removes the element at a given index of a heap array and moves every higher element down one slot.
- Returns the removed value and the new array length.
- Sits beside the instruction sequencer; drives the heap through one read port and one write port.

---
 rtl/array_shift_down.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/array_shift_down.sv
// array_shift_down: multi-cycle engine for the shiftDown array instruction.
// Removes the element at `index` of heap array `array`, moves every higher
// element down one slot and returns the removed value plus the new length.
// The heap is reached through one read port (1-cycle latency) and one write
// port; the MOV phase reads and writes different addresses in the same cycle.
//
// Optional build macro: ARRAY_SHIFT_DOWN_CLEAR_TAIL_EN
//   defined   -> a CLR state zeroes the vacated top slot before FIN
//   undefined -> no CLR state, the vacated slot keeps its old value
//
// Handshake: start is sampled only in IDLE. A request is accepted on the
// rising edge where state is IDLE and start=1; busy is high from the next
// cycle until and including the single-cycle done pulse. error, value and
// sizeOut/sizeWe are meaningful only while done=1. start seen while busy is
// dropped, never queued and never acknowledged.
module array_shift_down #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 2,
  localparam int W                 = MemoryElementWidth
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] array,
  input  logic [W-1:0] index,
  input  logic [W-1:0] size,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [W-1:0] value,
  output logic [W-1:0] sizeOut,
  output logic         sizeWe,
  output logic [W-1:0] memAddrR,
  output logic         memRe,
  input  logic [W-1:0] memRdata,
  output logic [W-1:0] memAddrW,
  output logic         memWe,
  output logic [W-1:0] memWdata,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDV  = 3'd1,
    S_CAP  = 3'd2,
    S_MOV  = 3'd3,
    S_CLR  = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  localparam logic [W-1:0] NAREA_W   = W'(NArea);
  localparam logic [W-1:0] NARRAYS_W = W'(NArrays);

  state_e       state_q;
  logic [W-1:0] base_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] len_q;

  logic         busy_q;
  logic         done_q;
  logic         error_q;
  logic [W-1:0] value_q;
  logic [W-1:0] sizeOut_q;
  logic         sizeWe_q;
  logic [W-1:0] memAddrR_q;
  logic         memRe_q;
  logic [W-1:0] memAddrW_q;
  logic         memWe_q;

  // Helper arithmetic, all modulo 2^W.
  logic [W-1:0] base_d;
  logic [W-1:0] ptr_p1;
  logic [W-1:0] ptr_p2;
  logic [W-1:0] ptr_p3;
  logic [W-1:0] len_m1;
  logic         reject;
  logic         last_step;

  assign base_d = NAREA_W * array;
  assign ptr_p1 = ptr_q + W'(1);
  assign ptr_p2 = ptr_q + W'(2);
  assign ptr_p3 = ptr_q + W'(3);
  assign len_m1 = len_q - W'(1);
  assign reject = (array >= NARRAYS_W) || (size == '0) || (index >= size);

  // The copy/capture phase ends when no further element above ptr remains.
  assign last_step = ((state_q == S_CAP) && !(ptr_p1 < len_q)) ||
                     ((state_q == S_MOV) && !(ptr_p2 < len_q));

  // Main sequencer; every output below is registered for the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      value_q    <= '0;
      sizeOut_q  <= '0;
      sizeWe_q   <= 1'b0;
      memAddrR_q <= '0;
      memRe_q    <= 1'b0;
      memAddrW_q <= '0;
      memWe_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      sizeWe_q <= 1'b0;
      memRe_q  <= 1'b0;
      memWe_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_d;
            ptr_q  <= index;
            len_q  <= size;
            busy_q <= 1'b1;
            if (reject) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q    <= S_RDV;
              memRe_q    <= 1'b1;
              memAddrR_q <= base_d + index;
            end
          end
        end
        S_RDV: begin
          // Prefetch the first element that has to move down.
          state_q    <= S_CAP;
          memRe_q    <= (ptr_p1 < len_q);
          memAddrR_q <= base_q + ptr_p1;
        end
        S_CAP: begin
          value_q <= memRdata;
          if (ptr_p1 < len_q) begin
            state_q    <= S_MOV;
            memWe_q    <= 1'b1;
            memAddrW_q <= base_q + ptr_q;
            memRe_q    <= (ptr_p2 < len_q);
            memAddrR_q <= base_q + ptr_p2;
          end
        end
        S_MOV: begin
          ptr_q <= ptr_p1;
          if (ptr_p2 < len_q) begin
            memWe_q    <= 1'b1;
            memAddrW_q <= base_q + ptr_p1;
            memRe_q    <= (ptr_p3 < len_q);
            memAddrR_q <= base_q + ptr_p3;
          end
        end
        S_CLR: begin
          state_q   <= S_FIN;
          done_q    <= 1'b1;
          sizeWe_q  <= 1'b1;
          sizeOut_q <= len_m1;
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (last_step) begin
`ifdef ARRAY_SHIFT_DOWN_CLEAR_TAIL_EN
        state_q    <= S_CLR;
        memWe_q    <= 1'b1;
        memAddrW_q <= base_q + len_m1;
`else
        state_q   <= S_FIN;
        done_q    <= 1'b1;
        sizeWe_q  <= 1'b1;
        sizeOut_q <= len_m1;
`endif
      end
    end
  end

  // Write data is the word read one cycle earlier, so it passes straight from
  // the read port during MOV; every other state (including CLR) writes zero.
  always_comb begin
    memWdata = '0;
    if (state_q == S_MOV) memWdata = memRdata;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign value       = value_q;
  assign sizeOut     = sizeOut_q;
  assign sizeWe      = sizeWe_q;
  assign memAddrR    = memAddrR_q;
  assign memRe       = memRe_q;
  assign memAddrW    = memAddrW_q;
  assign memWe       = memWe_q;
  assign dbg_state_o = state_q;

endmodule
